hv_scan_reg_bist_rsp: RTL
=========================

Name: hv_scan_reg_bist_rsp

Overview:
Responder side of the HV scan-register BIST handshake. It answers each BIST scan request by reading the next scan register through a read port. It checks the parity of the returned word and returns a one-cycle ack with a pass/fail flag. It sits between the HV BIST controller and the scan register bank.

Parameters:
HV_SCAN_REG_NUM, 8, number of scan registers walked per BIST session.
REG_DW, 8, scan register data width.
PAR_ODD, 1, 1 = odd parity (^{data,par}==1 is good); 0 = even parity (^{data,par}==0 is good).
RD_TMO_TH, 16, maximum cycles spent in RD waiting for i_scan_rd_ack.

Ports:
i_clk  in  1  clock.
i_rst_n  in  1  reset, asynchronous, active-low.
i_bist_en  in  1  BIST session enable; low aborts the session and clears state.
i_bist_scan_reg_req  in  1  level request from the BIST controller; drops the cycle after ack.
o_scan_reg_bist_ack  out  1  one-cycle ack pulse per request.
o_scan_reg_bist_err  out  1  valid only with ack; 1 = parity fail or read timeout.
o_scan_rd_req  out  1  read request to the scan register bank; held until i_scan_rd_ack or timeout.
o_scan_rd_addr  out  ADDR_W  register index; ADDR_W = $clog2(HV_SCAN_REG_NUM).
i_scan_rd_ack  in  1  read data valid; sampled only in RD.
i_scan_rd_data  in  REG_DW  read data.
i_scan_rd_par  in  1  stored parity bit.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; idx=0; timeout counter=0.
- FSM states: IDLE, RD, CHK, ACK (one-hot, registered outputs decoded from state).
- IDLE -> RD when i_bist_en & i_bist_scan_reg_req. Entering RD clears the timeout counter.
- RD: o_scan_rd_req=1 and o_scan_rd_addr=idx.
  - On i_scan_rd_ack: capture data and parity into registers, set tmo_flag=0, go to CHK.
  - When tmo_cnt==RD_TMO_TH-1 without an ack: set tmo_flag=1, go to CHK.
  - If ack and timeout occur in the same cycle, the ack wins and the data is checked.
- CHK: compute par_err = (^{data,par}) != PAR_ODD. Register err = tmo_flag | par_err. Go to ACK.
- ACK: o_scan_reg_bist_ack=1 and o_scan_reg_bist_err=err for exactly one cycle.
  - idx advances to idx+1, wrapping HV_SCAN_REG_NUM-1 -> 0.
  - Next state is IDLE.
- Latency: the request is sampled at edge e0. RD is active in cycle 1; with i_scan_rd_ack in cycle 1, ack is in cycle 3. Each wait cycle adds 1.
- Request handling:
  - The request is not re-sampled until the FSM is back in IDLE.
  - The controller drops its request the cycle after ack, so no double trigger occurs.
  - A request while i_bist_en=0 is ignored.
- Abort: i_bist_en=0 in any state has these synchronous effects at the next edge:
  - FSM -> IDLE, idx=0, tmo counter=0.
  - o_scan_rd_req, ack and err all 0.
  - No ack is issued for the aborted request.
  - A late i_scan_rd_ack outside RD is ignored.
- The timeout counter width is $clog2(RD_TMO_TH). It saturates and does not wrap.

Optional Feature:
Macro HV_SCAN_BIST_ERR_LOG_EN.
With the macro defined, three extra outputs exist:
- o_scan_err_cnt: $clog2(HV_SCAN_REG_NUM+1) bits, count of errored acks in the session, saturating.
- o_scan_first_err_addr: ADDR_W bits, idx of the first errored ack.
- o_scan_first_err_vld: 1 bit, set on the first errored ack.
All three reset to 0, clear when i_bist_en=0, and update in the ACK cycle.
Without the macro, these ports and their logic are absent; the core behaviour is identical.

Decomposition:
- Package hv_scan_bist_pkg holds:
  - the state enum (IDLE/RD/CHK/ACK);
  - the ADDR_W and TMO_CNT_W derivation functions;
  - the PAR_ODD encoding constants.
- Sub-module hv_scan_par_chk: purely combinational REG_DW-bit parity check (data, par, odd) -> par_err. It is reused by other parity-protected banks.

Test Plan:
- Reset: hold i_rst_n=0 -> all outputs 0, o_scan_rd_addr=0. Release -> stays idle with no request.
- Clean read, PAR_ODD=1: request, rd_ack in cycle 1 with data=8'hA5, par=1 -> ack in cycle 3, err=0, addr=0. The next request gives addr=1.
- Parity fail: data=8'hA5, par=0 -> ack with err=1. With the macro on: err_cnt=1, first_err_addr=idx, vld=1.
- Timeout: hold i_scan_rd_ack=0 -> o_scan_rd_req drops after 16 cycles in RD. Ack with err=1 follows 2 cycles later. A rd_ack on the 16th cycle instead gives err=0 when parity is good.
- Walk and wrap: 9 back-to-back requests with good data -> addresses 0..7 then 0. 9 acks, all err=0.
- Abort: drop i_bist_en while in RD, then pulse i_scan_rd_ack -> no ack, rd_req=0 next cycle. After re-enabling, the first address is 0.

Source files
------------

// File: rtl/hv_scan_bist_pkg.sv
// -----------------------------------------------------------------------------
// hv_scan_bist_pkg
// Shared definitions for the HV scan-register BIST responder and related
// parity-protected banks.
//   state_e        : one-hot responder FSM state encoding (IDLE/RD/CHK/ACK)
//   PAR_*_ENC      : encoding of the parity-sense input of hv_scan_par_chk
//   addr_w_f       : register index width for a bank of n registers
//   tmo_cnt_w_f    : width of the read-timeout counter for a threshold th
// -----------------------------------------------------------------------------
package hv_scan_bist_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'b0001,
      ST_RD   = 4'b0010,
      ST_CHK  = 4'b0100,
      ST_ACK  = 4'b1000
   } state_e;

   // Parity sense: odd means ^{data,par}==1 is a good word.
   localparam logic PAR_EVEN_ENC = 1'b0;
   localparam logic PAR_ODD_ENC  = 1'b1;

   // At least one bit so a single-register bank still has a legal port.
   function automatic int addr_w_f(input int n);
      if (n <= 2) return 1;
      return $clog2(n);
   endfunction

   function automatic int tmo_cnt_w_f(input int th);
      if (th <= 2) return 1;
      return $clog2(th);
   endfunction

endpackage

// File: rtl/hv_scan_par_chk.sv
// -----------------------------------------------------------------------------
// hv_scan_par_chk
// Purely combinational parity check of a REG_DW-bit word against its stored
// parity bit. Shared by every parity-protected scan bank.
// Ports:
//   i_data     [REG_DW-1:0] data word
//   i_par                   stored parity bit
//   i_odd                   parity sense (PAR_ODD_ENC / PAR_EVEN_ENC)
//   o_par_err               1 = word and parity disagree with the sense
// -----------------------------------------------------------------------------
module hv_scan_par_chk #(
   parameter int REG_DW = 8
) (
   input  logic [REG_DW-1:0] i_data,
   input  logic              i_par,
   input  logic              i_odd,
   output logic              o_par_err
);

   logic w_xor;

   assign w_xor     = ^{i_data, i_par};
   assign o_par_err = (w_xor != i_odd);

endmodule

// File: rtl/hv_scan_reg_bist_rsp.sv
// -----------------------------------------------------------------------------
// hv_scan_reg_bist_rsp
// Responder side of the HV scan-register BIST handshake. Each BIST request
// reads the next scan register through the bank read port, checks the parity
// of the returned word and answers with a one-cycle ack carrying a pass/fail
// flag. Registers are walked 0..HV_SCAN_REG_NUM-1 and wrap.
//
// Parameters:
//   HV_SCAN_REG_NUM  number of scan registers walked per session
//   REG_DW           scan register data width
//   PAR_ODD          1 = odd parity good, 0 = even parity good
//   RD_TMO_TH        maximum cycles spent waiting for i_scan_rd_ack
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_bist_en                session enable; low aborts and clears state
//   i_bist_scan_reg_req      level request from the BIST controller
//   o_scan_reg_bist_ack      one-cycle ack per request
//   o_scan_reg_bist_err      valid with ack: parity fail or read timeout
//   o_scan_rd_req            read request to the bank, held in RD
//   o_scan_rd_addr           register index being read
//   i_scan_rd_ack            read data valid (only looked at in RD)
//   i_scan_rd_data           read data
//   i_scan_rd_par            stored parity bit
//
// Optional build macro HV_SCAN_BIST_ERR_LOG_EN adds an error log:
//   o_scan_err_cnt           saturating count of errored acks in the session
//   o_scan_first_err_addr    index of the first errored ack
//   o_scan_first_err_vld     set once the first errored ack has been seen
// -----------------------------------------------------------------------------
module hv_scan_reg_bist_rsp
   import hv_scan_bist_pkg::*;
#(
   parameter  int HV_SCAN_REG_NUM = 8,
   parameter  int REG_DW          = 8,
   parameter  int PAR_ODD         = 1,
   parameter  int RD_TMO_TH       = 16,
   localparam int ADDR_W          = addr_w_f(HV_SCAN_REG_NUM)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_bist_en,
   input  logic              i_bist_scan_reg_req,
   output logic              o_scan_reg_bist_ack,
   output logic              o_scan_reg_bist_err,
   output logic              o_scan_rd_req,
   output logic [ADDR_W-1:0] o_scan_rd_addr,
   input  logic              i_scan_rd_ack,
   input  logic [REG_DW-1:0] i_scan_rd_data,
   input  logic              i_scan_rd_par
`ifdef HV_SCAN_BIST_ERR_LOG_EN
   ,
   output logic [$clog2(HV_SCAN_REG_NUM+1)-1:0] o_scan_err_cnt,
   output logic [ADDR_W-1:0]                    o_scan_first_err_addr,
   output logic                                 o_scan_first_err_vld
`endif
);

   localparam int   TMO_CNT_W = tmo_cnt_w_f(RD_TMO_TH);
   localparam logic PAR_SENSE = (PAR_ODD != 0) ? PAR_ODD_ENC : PAR_EVEN_ENC;

   localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(RD_TMO_TH - 1);
   localparam logic [TMO_CNT_W-1:0] TMO_SAT  = {TMO_CNT_W{1'b1}};
   localparam logic [ADDR_W-1:0]    IDX_LAST = ADDR_W'(HV_SCAN_REG_NUM - 1);

   state_e                r_state;
   logic [ADDR_W-1:0]     r_idx;
   logic [TMO_CNT_W-1:0]  r_tmo_cnt;
   logic                  r_tmo_flag;
   logic [REG_DW-1:0]     r_rd_data;
   logic                  r_rd_par;

   logic                  w_odd;
   logic                  w_par_err;
   logic                  w_err;

   assign w_odd = PAR_SENSE;

   hv_scan_par_chk #(
      .REG_DW (REG_DW)
   ) u_par_chk (
      .i_data    (r_rd_data),
      .i_par     (r_rd_par),
      .i_odd     (w_odd),
      .o_par_err (w_par_err)
   );

   // A timed-out read carries stale data; the timeout flag alone decides.
   assign w_err = r_tmo_flag | w_par_err;

   // Read data capture: datapath only, no reset needed.
   always_ff @(posedge i_clk) begin
      if (r_state == ST_RD && i_scan_rd_ack) begin
         r_rd_data <= i_scan_rd_data;
         r_rd_par  <= i_scan_rd_par;
      end
   end

   // Responder FSM with registered outputs. Outputs are set on the edge that
   // enters the state in which they must be visible.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state             <= ST_IDLE;
         r_idx               <= '0;
         r_tmo_cnt           <= '0;
         r_tmo_flag          <= 1'b0;
         o_scan_rd_req       <= 1'b0;
         o_scan_rd_addr      <= '0;
         o_scan_reg_bist_ack <= 1'b0;
         o_scan_reg_bist_err <= 1'b0;
      end else if (!i_bist_en) begin
         // Abort: drop any request in flight without acking it.
         r_state             <= ST_IDLE;
         r_idx               <= '0;
         r_tmo_cnt           <= '0;
         r_tmo_flag          <= 1'b0;
         o_scan_rd_req       <= 1'b0;
         o_scan_rd_addr      <= '0;
         o_scan_reg_bist_ack <= 1'b0;
         o_scan_reg_bist_err <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               o_scan_reg_bist_ack <= 1'b0;
               o_scan_reg_bist_err <= 1'b0;
               if (i_bist_scan_reg_req) begin
                  r_state        <= ST_RD;
                  r_tmo_cnt      <= '0;
                  o_scan_rd_req  <= 1'b1;
                  o_scan_rd_addr <= r_idx;
               end
            end

            ST_RD: begin
               // Ack is tested first so it wins over a same-cycle timeout.
               if (i_scan_rd_ack) begin
                  r_state        <= ST_CHK;
                  r_tmo_flag     <= 1'b0;
                  o_scan_rd_req  <= 1'b0;
                  o_scan_rd_addr <= '0;
               end else if (r_tmo_cnt == TMO_LAST) begin
                  r_state        <= ST_CHK;
                  r_tmo_flag     <= 1'b1;
                  o_scan_rd_req  <= 1'b0;
                  o_scan_rd_addr <= '0;
               end else if (r_tmo_cnt != TMO_SAT) begin
                  r_tmo_cnt <= r_tmo_cnt + TMO_CNT_W'(1);
               end
            end

            ST_CHK: begin
               r_state             <= ST_ACK;
               o_scan_reg_bist_ack <= 1'b1;
               o_scan_reg_bist_err <= w_err;
            end

            ST_ACK: begin
               r_state             <= ST_IDLE;
               o_scan_reg_bist_ack <= 1'b0;
               o_scan_reg_bist_err <= 1'b0;
               r_idx               <= (r_idx == IDX_LAST) ? '0 : r_idx + ADDR_W'(1);
            end

            default: begin
               r_state             <= ST_IDLE;
               o_scan_rd_req       <= 1'b0;
               o_scan_rd_addr      <= '0;
               o_scan_reg_bist_ack <= 1'b0;
               o_scan_reg_bist_err <= 1'b0;
            end
         endcase
      end
   end

`ifdef HV_SCAN_BIST_ERR_LOG_EN
   localparam int ERR_CNT_W = $clog2(HV_SCAN_REG_NUM + 1);
   localparam logic [ERR_CNT_W-1:0] ERR_CNT_SAT = {ERR_CNT_W{1'b1}};

   // Updated on the CHK->ACK edge so the log is current while ack is high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_scan_err_cnt        <= '0;
         o_scan_first_err_addr <= '0;
         o_scan_first_err_vld  <= 1'b0;
      end else if (!i_bist_en) begin
         o_scan_err_cnt        <= '0;
         o_scan_first_err_addr <= '0;
         o_scan_first_err_vld  <= 1'b0;
      end else if (r_state == ST_CHK && w_err) begin
         if (o_scan_err_cnt != ERR_CNT_SAT) begin
            o_scan_err_cnt <= o_scan_err_cnt + ERR_CNT_W'(1);
         end
         if (!o_scan_first_err_vld) begin
            o_scan_first_err_vld  <= 1'b1;
            o_scan_first_err_addr <= r_idx;
         end
      end
   end
`endif

endmodule
